bootrom_arbiter: RTL

- Shares the single-port, synchronous-read boot ROM (32-bit words, 9-bit byte address, 1-cycle read latency) between the CPU instruction bus (ibus) and data bus (dbus).
- Sits between the aq32 core bus decode and the boot ROM. Upstream decode has already selected the ROM window.
- Round-robin arbitration, at most one access outstanding. Writes from dbus are absorbed and acknowledged.

---
 rtl/aq32_bus_pkg.sv | 16 +
 rtl/rr_arb2.sv | 39 +++
 rtl/bootrom_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/aq32_bus_pkg.sv
// Shared aq32 bus definitions: master indices, ROM word width and the
// per-master request bundle used by the ROM and RAM port arbiters.
package aq32_bus_pkg;

  localparam int DATA_W = 32;

  localparam logic MST_IBUS = 1'b0;
  localparam logic MST_DBUS = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        req;
    logic        wr;
  } bus_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with an internal last-granted pointer and
// an eligibility mask; the pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic [1:0] elig;
  logic       last_q;
  logic       last_d;

  always_comb begin
    elig    = req & ~mask;
    gnt_vld = |elig;
    gnt_idx = 1'b0;
    last_d  = last_q;
    if (&elig) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = elig[1];
    end
    if (gnt_vld) begin
      last_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bootrom_arbiter.sv
// Shares the synchronous-read boot ROM between ibus and dbus, one access in
// flight. Optional macro BOOTROM_ARB_WRERR_EN adds dbus_err for write accesses.
module bootrom_arbiter
  import aq32_bus_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = aq32_bus_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       ibus_addr,
  input  logic              ibus_req,
  output logic              ibus_ack,
  output logic [DATA_W-1:0] ibus_rddata,
  input  logic [31:0]       dbus_addr,
  input  logic              dbus_req,
  input  logic              dbus_wr,
  output logic              dbus_ack,
  output logic [DATA_W-1:0] dbus_rddata,
`ifdef BOOTROM_ARB_WRERR_EN
  output logic              dbus_err,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rddata
);

  bus_req_t [1:0] mst;
  bus_req_t       win;
  logic [1:0]     req_v;
  logic [1:0]     mask_v;
  logic           gnt_vld;
  logic           gnt_idx;

  logic pend_q, pend_d;
  logic owner_q, owner_d;
`ifdef BOOTROM_ARB_WRERR_EN
  logic wr_q, wr_d;
`endif

  always_comb begin
    mst[MST_IBUS] = '{addr: ibus_addr, req: ibus_req, wr: 1'b0};
    mst[MST_DBUS] = '{addr: dbus_addr, req: dbus_req, wr: dbus_wr};
    // Nothing is granted while reset is held, so rom_addr reads 0 then.
    req_v[MST_IBUS]  = mst[MST_IBUS].req & reset_n;
    req_v[MST_DBUS]  = mst[MST_DBUS].req & reset_n;
    mask_v[MST_IBUS] = pend_q & (owner_q == MST_IBUS);
    mask_v[MST_DBUS] = pend_q & (owner_q == MST_DBUS);
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_v),
    .mask    (mask_v),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    win      = mst[gnt_idx];
    rom_addr = '0;
    pend_d   = gnt_vld;
    owner_d  = owner_q;
    if (gnt_vld) begin
      rom_addr = win.addr[ADDR_W-1:0];
      owner_d  = gnt_idx;
    end
`ifdef BOOTROM_ARB_WRERR_EN
    wr_d = wr_q;
    if (gnt_vld) begin
      wr_d = win.wr;
      if (win.wr) begin
        rom_addr = '0;
      end
    end
`endif
  end

  // Ack cycle: ack is suppressed while reset is held, so a lost access never acks.
  always_comb begin
    ibus_ack    = pend_q & reset_n & (owner_q == MST_IBUS);
    dbus_ack    = pend_q & reset_n & (owner_q == MST_DBUS);
    ibus_rddata = rom_rddata;
    dbus_rddata = rom_rddata;
`ifdef BOOTROM_ARB_WRERR_EN
    dbus_err    = dbus_ack & wr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q  <= 1'b0;
      owner_q <= MST_IBUS;
`ifdef BOOTROM_ARB_WRERR_EN
      wr_q    <= 1'b0;
`endif
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
`ifdef BOOTROM_ARB_WRERR_EN
      wr_q    <= wr_d;
`endif
    end
  end

  // Address bits above the ROM window alias; request/write flags of the
  // winner are consumed elsewhere or not at all.
  logic unused_win;
  assign unused_win = ^{win.addr[31:ADDR_W], win.req, win.wr};

endmodule
